// File: rtl/apb_bridge_controller.sv
// ---------------------------------------------------------------------------
// apb_bridge_controller
//
// Transfer sequencer for the AHB-to-APB bridge. It accepts qualified AHB
// transfers from the slave interface, runs the matching APB setup/access
// sequence and stretches the AHB data phase with hready_out while the APB
// access is in flight.
//
//   read  : IDLE -> READ  -> RENABLE                (1 AHB wait state)
//   write : IDLE -> WWAIT -> WRITE -> WENABLE       (2 AHB wait states)
//
// RENABLE and WENABLE branch straight into the next transfer, so
// back-to-back traffic never passes through IDLE.
//
// Build option:
//   APB_PREADY_EN  adds the pready input. The access states are held while
//                  pready is low, and hready_out follows pready in those
//                  two states. Without it every access phase lasts exactly
//                  one cycle.
// ---------------------------------------------------------------------------
module apb_bridge_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
`ifdef APB_PREADY_EN
  input  logic              pready,
`endif
  output logic [NSLV-1:0]   pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hready_out
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_RENABLE = 3'd2,
    ST_WWAIT   = 3'd3,
    ST_WRITE   = 3'd4,
    ST_WENABLE = 3'd5
  } state_t;

  // APB slave windows: slave 0 below SLV1_BASE, slave 1 up to SLV2_BASE,
  // slave 2 up to DECODE_TOP, nothing selected above that.
  localparam logic [ADDR_W-1:0] SLV1_BASE  = ADDR_W'(64'h8400_0000);
  localparam logic [ADDR_W-1:0] SLV2_BASE  = ADDR_W'(64'h8800_0000);
  localparam logic [ADDR_W-1:0] DECODE_TOP = ADDR_W'(64'h8C00_0000);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;     // transfer address captured when leaving IDLE/xENABLE
  logic              hready_q;   // registered AHB ready
  logic              access_done;
  logic              in_access;

  // One-hot slave select for the address about to be driven on paddr.
  // Unmapped addresses select nobody; the sequence still completes.
  function automatic logic [NSLV-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [NSLV-1:0] sel;
    sel = '0;
    if (a < SLV1_BASE)       sel = NSLV'(1);
    else if (a < SLV2_BASE)  sel = NSLV'(2);
    else if (a < DECODE_TOP) sel = NSLV'(4);
    return sel;
  endfunction

  assign in_access = (state == ST_RENABLE) || (state == ST_WENABLE);

`ifdef APB_PREADY_EN
  // The access phase ends on the first cycle the slave reports ready.
  assign access_done = pready;
  // In the access states the AHB side sees the slave's ready directly, so a
  // stalled slave stretches the AHB data phase without an extra cycle.
  assign hready_out  = in_access ? pready : hready_q;
`else
  assign access_done = 1'b1;
  assign hready_out  = hready_q;
`endif

  // Sequencer: state plus every APB output, each loaded on the edge that
  // enters the state in which it must hold.
  // NOTE: all state and outputs use non-blocking assignments so every
  // branch reads the pre-edge values; a blocking write here would let a
  // later statement see the new state mid-cycle and break the sequencing.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      pselx    <= '0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      hready_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_RENABLE, ST_WENABLE: begin
          if (in_access && !access_done) begin
            // Slave still busy: hold state and every APB output.
            state <= state;
          end else if (valid && !hwrite) begin
            // Read setup drives the live address straight away; the
            // internal copy is kept for consistency with the write path.
            state    <= ST_READ;
            addr_q   <= haddr;
            paddr    <= haddr;
            pselx    <= decode(haddr);
            pwrite   <= 1'b0;
            penable  <= 1'b0;
            hready_q <= 1'b0;
          end else if (valid && hwrite) begin
            // Write data is not on the bus yet; park with no slave selected.
            state    <= ST_WWAIT;
            addr_q   <= haddr;
            pselx    <= '0;
            penable  <= 1'b0;
            hready_q <= 1'b0;
          end else begin
            // pwrite, paddr and pwdata keep their last values in IDLE.
            state    <= ST_IDLE;
            pselx    <= '0;
            penable  <= 1'b0;
            hready_q <= 1'b1;
          end
        end

        ST_READ: begin
          state    <= ST_RENABLE;
          penable  <= 1'b1;
          hready_q <= 1'b1;
        end

        ST_WWAIT: begin
          // hwdata is stable during this held data phase; capture it now.
          state    <= ST_WRITE;
          pwdata   <= hwdata;
          paddr    <= addr_q;
          pwrite   <= 1'b1;
          pselx    <= decode(addr_q);
          penable  <= 1'b0;
          hready_q <= 1'b0;
        end

        ST_WRITE: begin
          state    <= ST_WENABLE;
          penable  <= 1'b1;
          hready_q <= 1'b1;
        end

        default: begin
          // Unused encodings fall back to IDLE with reset-valued outputs.
          state    <= ST_IDLE;
          addr_q   <= '0;
          pselx    <= '0;
          penable  <= 1'b0;
          pwrite   <= 1'b0;
          paddr    <= '0;
          pwdata   <= '0;
          hready_q <= 1'b1;
        end
      endcase
    end
  end

  // Protocol invariants of the sequencer.
  a_psel_onehot : assert property (@(posedge hclk) disable iff (!hresetn)
    $onehot0(pselx));
  a_no_psel_idle : assert property (@(posedge hclk) disable iff (!hresetn)
    (state == ST_IDLE || state == ST_WWAIT) |-> (pselx == '0));
  a_penable_access : assert property (@(posedge hclk) disable iff (!hresetn)
    penable |-> in_access);
  a_setup_then_access : assert property (@(posedge hclk) disable iff (!hresetn)
    (state == ST_READ || state == ST_WRITE) |=> penable);

endmodule

// File: tb/tb_apb_bridge_controller.sv
// ---------------------------------------------------------------------------
// Directed testbench for apb_bridge_controller. Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point, well away
// from the active edge. Build with +define+APB_PREADY_EN to add the pready
// scenario.
// ---------------------------------------------------------------------------
module tb_apb_bridge_controller;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NSLV   = 3;

  logic              hclk;
  logic              hresetn;
  logic              valid;
  logic              hwrite;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic [NSLV-1:0]   pselx;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              hready_out;
`ifdef APB_PREADY_EN
  logic              pready;
`endif

  int checks;
  int failures;

  apb_bridge_controller #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .NSLV  (NSLV)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .valid     (valid),
    .hwrite    (hwrite),
    .haddr     (haddr),
    .hwdata    (hwdata),
`ifdef APB_PREADY_EN
    .pready    (pready),
`endif
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .hready_out(hready_out)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Start a transfer from IDLE/xENABLE and advance into its first state.
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a);
    valid  = 1'b1;
    hwrite = wr;
    haddr  = a;
    tick();
    valid  = 1'b0;
    hwrite = 1'b0;
    haddr  = '0;
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    valid   = 1'b0;
    hwrite  = 1'b0;
    haddr   = '0;
    hwdata  = '0;
`ifdef APB_PREADY_EN
    pready  = 1'b1;
`endif
    tick();
    tick();
    checks++; if (pselx !== 3'b000) begin failures++; $display("FAIL rst_pselx got=%b exp=%b", pselx, 3'b000); end
    checks++; if (penable !== 1'b0) begin failures++; $display("FAIL rst_penable got=%b exp=0", penable); end
    checks++; if (pwrite !== 1'b0) begin failures++; $display("FAIL rst_pwrite got=%b exp=0", pwrite); end
    checks++; if (paddr !== 32'h0) begin failures++; $display("FAIL rst_paddr got=%h exp=00000000", paddr); end
    checks++; if (pwdata !== 32'h0) begin failures++; $display("FAIL rst_pwdata got=%h exp=00000000", pwdata); end
    checks++; if (hready_out !== 1'b1) begin failures++; $display("FAIL rst_hready got=%b exp=1", hready_out); end
    hresetn = 1'b1;
    tick();
  endtask

  task automatic test_read();
    issue(1'b0, 32'h8000_0010);   // now in READ
    checks++; if (pselx !== 3'b001) begin failures++; $display("FAIL rd_setup_pselx got=%b exp=001", pselx); end
    checks++; if (paddr !== 32'h8000_0010) begin failures++; $display("FAIL rd_setup_paddr got=%h exp=80000010", paddr); end
    checks++; if (pwrite !== 1'b0) begin failures++; $display("FAIL rd_setup_pwrite got=%b exp=0", pwrite); end
    checks++; if (penable !== 1'b0) begin failures++; $display("FAIL rd_setup_penable got=%b exp=0", penable); end
    checks++; if (hready_out !== 1'b0) begin failures++; $display("FAIL rd_setup_hready got=%b exp=0", hready_out); end
    tick();                        // RENABLE
    checks++; if (penable !== 1'b1) begin failures++; $display("FAIL rd_access_penable got=%b exp=1", penable); end
    checks++; if (hready_out !== 1'b1) begin failures++; $display("FAIL rd_access_hready got=%b exp=1", hready_out); end
    checks++; if (pselx !== 3'b001) begin failures++; $display("FAIL rd_access_pselx got=%b exp=001", pselx); end
    tick();                        // IDLE
    checks++; if (pselx !== 3'b000) begin failures++; $display("FAIL rd_idle_pselx got=%b exp=000", pselx); end
    checks++; if (penable !== 1'b0) begin failures++; $display("FAIL rd_idle_penable got=%b exp=0", penable); end
    checks++; if (paddr !== 32'h8000_0010) begin failures++; $display("FAIL rd_idle_paddr_hold got=%h exp=80000010", paddr); end
  endtask

  task automatic test_write();
    issue(1'b1, 32'h8400_0004);   // WWAIT
    hwdata = 32'hDEAD_BEEF;
    checks++; if (hready_out !== 1'b0) begin failures++; $display("FAIL wr_wait_hready got=%b exp=0", hready_out); end
    checks++; if (pselx !== 3'b000) begin failures++; $display("FAIL wr_wait_pselx got=%b exp=000", pselx); end
    checks++; if (penable !== 1'b0) begin failures++; $display("FAIL wr_wait_penable got=%b exp=0", penable); end
    tick();                        // WRITE
    hwdata = 32'h0;
    checks++; if (pselx !== 3'b010) begin failures++; $display("FAIL wr_setup_pselx got=%b exp=010", pselx); end
    checks++; if (pwrite !== 1'b1) begin failures++; $display("FAIL wr_setup_pwrite got=%b exp=1", pwrite); end
    checks++; if (pwdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_setup_pwdata got=%h exp=deadbeef", pwdata); end
    checks++; if (paddr !== 32'h8400_0004) begin failures++; $display("FAIL wr_setup_paddr got=%h exp=84000004", paddr); end
    checks++; if (hready_out !== 1'b0) begin failures++; $display("FAIL wr_setup_hready got=%b exp=0", hready_out); end
    checks++; if (penable !== 1'b0) begin failures++; $display("FAIL wr_setup_penable got=%b exp=0", penable); end
    tick();                        // WENABLE
    checks++; if (penable !== 1'b1) begin failures++; $display("FAIL wr_access_penable got=%b exp=1", penable); end
    checks++; if (hready_out !== 1'b1) begin failures++; $display("FAIL wr_access_hready got=%b exp=1", hready_out); end
    checks++; if (pwdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_access_pwdata got=%h exp=deadbeef", pwdata); end
    tick();                        // IDLE
    checks++; if (pselx !== 3'b000) begin failures++; $display("FAIL wr_idle_pselx got=%b exp=000", pselx); end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 32'h8800_0000);   // WWAIT
    hwdata = 32'h1234_5678;
    tick();                        // WRITE
    checks++; if (pselx !== 3'b100) begin failures++; $display("FAIL b2b_wr_pselx got=%b exp=100", pselx); end
    tick();                        // WENABLE
    checks++; if (penable !== 1'b1) begin failures++; $display("FAIL b2b_wr_penable got=%b exp=1", penable); end
    issue(1'b0, 32'h8800_0008);   // straight into READ
    checks++; if (pselx !== 3'b100) begin failures++; $display("FAIL b2b_rd_pselx got=%b exp=100", pselx); end
    checks++; if (paddr !== 32'h8800_0008) begin failures++; $display("FAIL b2b_rd_paddr got=%h exp=88000008", paddr); end
    checks++; if (pwrite !== 1'b0) begin failures++; $display("FAIL b2b_rd_pwrite got=%b exp=0", pwrite); end
    checks++; if (penable !== 1'b0) begin failures++; $display("FAIL b2b_rd_penable got=%b exp=0", penable); end
    checks++; if (hready_out !== 1'b0) begin failures++; $display("FAIL b2b_rd_hready got=%b exp=0", hready_out); end
    checks++; if (pwdata !== 32'h1234_5678) begin failures++; $display("FAIL b2b_pwdata_hold got=%h exp=12345678", pwdata); end
    tick();                        // RENABLE
    checks++; if (penable !== 1'b1) begin failures++; $display("FAIL b2b_rd_access got=%b exp=1", penable); end
    tick();                        // IDLE
  endtask

  task automatic test_decode();
    logic [ADDR_W-1:0] addrs [6];
    logic [NSLV-1:0]   sels  [6];
    addrs = '{32'h0000_0000, 32'h83FF_FFFC, 32'h8400_0000, 32'h87FF_FFFF, 32'h8BFF_FFFF, 32'h8C00_0000};
    sels  = '{3'b001,        3'b001,        3'b010,        3'b010,        3'b100,        3'b000};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, addrs[i]);       // READ
      checks++; if (pselx !== sels[i]) begin failures++; $display("FAIL dec_pselx[%0d] addr=%h got=%b exp=%b", i, addrs[i], pselx, sels[i]); end
      tick();                      // RENABLE: sequence completes even when unmapped
      checks++; if (penable !== 1'b1 || hready_out !== 1'b1) begin failures++; $display("FAIL dec_access[%0d] got penable=%b hready=%b exp 1/1", i, penable, hready_out); end
      tick();                      // IDLE
    end
  endtask

  task automatic test_idle_hold();
    valid = 1'b0;
    hwrite = 1'b1;
    haddr  = 32'h8400_0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (hready_out !== 1'b1 || pselx !== 3'b000 || penable !== 1'b0) begin
        failures++; $display("FAIL idle_hold[%0d] got hready=%b pselx=%b penable=%b exp 1/000/0", i, hready_out, pselx, penable);
      end
    end
    hwrite = 1'b0;
    haddr  = '0;
  endtask

  task automatic test_reset_mid_write();
    issue(1'b1, 32'h8400_0004);   // WWAIT
    hwdata = 32'hCAFE_F00D;
    tick();                        // WRITE
    checks++; if (paddr !== 32'h8400_0004) begin failures++; $display("FAIL mrst_pre_paddr got=%h exp=84000004", paddr); end
    #2 hresetn = 1'b0;
    #1;
    checks++; if (pselx !== 3'b000) begin failures++; $display("FAIL mrst_pselx got=%b exp=000", pselx); end
    checks++; if (penable !== 1'b0) begin failures++; $display("FAIL mrst_penable got=%b exp=0", penable); end
    checks++; if (paddr !== 32'h0) begin failures++; $display("FAIL mrst_paddr got=%h exp=00000000", paddr); end
    checks++; if (pwdata !== 32'h0) begin failures++; $display("FAIL mrst_pwdata got=%h exp=00000000", pwdata); end
    checks++; if (hready_out !== 1'b1) begin failures++; $display("FAIL mrst_hready got=%b exp=1", hready_out); end
    hwdata = '0;
    tick();
    hresetn = 1'b1;
    tick();                        // must be sitting in IDLE
    checks++; if (pselx !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1) begin
      failures++; $display("FAIL mrst_idle got pselx=%b penable=%b hready=%b exp 000/0/1", pselx, penable, hready_out);
    end
    issue(1'b0, 32'h8000_0020);   // IDLE accepts a read in one edge
    checks++; if (pselx !== 3'b001 || hready_out !== 1'b0) begin
      failures++; $display("FAIL mrst_restart got pselx=%b hready=%b exp 001/0", pselx, hready_out);
    end
    tick();
    tick();
  endtask

`ifdef APB_PREADY_EN
  task automatic test_pready();
    issue(1'b0, 32'h8000_0000);   // READ
    pready = 1'b0;
    tick();                        // RENABLE, stalled
    checks++; if (penable !== 1'b1 || hready_out !== 1'b0) begin failures++; $display("FAIL prdy_stall1 got penable=%b hready=%b exp 1/0", penable, hready_out); end
    tick();                        // still RENABLE
    checks++; if (penable !== 1'b1 || hready_out !== 1'b0) begin failures++; $display("FAIL prdy_stall2 got penable=%b hready=%b exp 1/0", penable, hready_out); end
    checks++; if (pselx !== 3'b001 || paddr !== 32'h8000_0000 || pwrite !== 1'b0) begin
      failures++; $display("FAIL prdy_hold got pselx=%b paddr=%h pwrite=%b exp 001/80000000/0", pselx, paddr, pwrite);
    end
    pready = 1'b1;
    #1;
    checks++; if (penable !== 1'b1 || hready_out !== 1'b1) begin failures++; $display("FAIL prdy_release got penable=%b hready=%b exp 1/1", penable, hready_out); end
    tick();                        // IDLE
    checks++; if (penable !== 1'b0 || pselx !== 3'b000) begin failures++; $display("FAIL prdy_exit got penable=%b pselx=%b exp 0/000", penable, pselx); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_decode();
    test_idle_hold();
    test_reset_mid_write();
`ifdef APB_PREADY_EN
    test_pready();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
